// File: rtl/digest_reader_if.sv
// Word-return channel between digest_reader and the processor.
interface digest_reader_if #(
  parameter int unsigned BUS_WIDTH = 64
);
  logic [BUS_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/digest_reader.sv
// Captures the hash engine digest on a rising digest_valid and returns it to the
// processor as BUS_WIDTH-bit words, least-significant word first, optionally truncated.
module digest_reader #(
  parameter int unsigned BUS_WIDTH    = 64,
  parameter int unsigned DIGEST_WIDTH = 512,
  parameter int unsigned OUT_WORDS    = DIGEST_WIDTH / BUS_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic                    digest_valid,
  input  logic                    abort,
  digest_reader_if.master         dout_if,
  output logic                    busy,
  output logic                    digest_done,
  output logic                    overrun
);

  localparam int unsigned IdxW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int unsigned OffW = (DIGEST_WIDTH > 1) ? $clog2(DIGEST_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OUT_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DIGEST_WIDTH-1:0] digest_q, digest_d;
  logic                    overrun_q, overrun_d;
  logic                    dv_q;
  logic                    capture;
  logic [OffW-1:0]         word_off;
  logic [BUS_WIDTH-1:0]    dout;
  logic                    dout_valid;
  logic                    dout_last;

  // A rising digest_valid; dv_q resets low so a level high at reset release counts.
  assign capture  = digest_valid & ~dv_q;
  assign word_off = OffW'(idx_q) * OffW'(BUS_WIDTH);

  // Next-state, capture/overrun bookkeeping and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    digest_d    = digest_q;
    overrun_d   = overrun_q;
    dout        = '0;
    dout_valid  = 1'b0;
    dout_last   = 1'b0;
    digest_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          digest_d = digest;
          idx_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        dout_valid = 1'b1;
        dout       = digest_q[word_off +: BUS_WIDTH];
        dout_last  = (idx_q == LastIdx);
        if (dout_if.dout_ready) begin
          if (dout_last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        digest_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new digest while one is still being returned is dropped and flagged.
    if (capture && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    // abort wins over everything, including a capture in the same cycle.
    if (abort) begin
      state_d   = StIdle;
      idx_d     = '0;
      digest_d  = '0;
      overrun_d = 1'b0;
    end
  end

  // State registers; dv_q tracks digest_valid regardless of abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      digest_q  <= '0;
      overrun_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      digest_q  <= digest_d;
      overrun_q <= overrun_d;
      dv_q      <= digest_valid;
    end
  end

  assign busy               = (state_q != StIdle);
  assign overrun            = overrun_q;
  assign dout_if.dout       = dout;
  assign dout_if.dout_valid = dout_valid;
  assign dout_if.dout_last  = dout_last;

endmodule

// File: tb/tb_digest_reader.sv
// Bench for digest_reader: a full-length (8-word) and a truncated (4-word) instance
// share one stimulus stream and are checked against a word-counting reference model,
// a vector table and a few directed sequences.
module tb_digest_reader;

  localparam int unsigned BW = 64;
  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          t_dv, t_ab, t_rdy;
  logic [DW-1:0] t_dg;
  logic          busy8, done8, ovr8, busy4, done4, ovr4;

  always #5 clk = ~clk;

  digest_reader_if #(.BUS_WIDTH(BW)) bus8 ();
  digest_reader_if #(.BUS_WIDTH(BW)) bus4 ();

  assign bus8.dout_ready = t_rdy;
  assign bus4.dout_ready = t_rdy;

  digest_reader #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .digest       (t_dg),
    .digest_valid (t_dv),
    .abort        (t_ab),
    .dout_if      (bus8.master),
    .busy         (busy8),
    .digest_done  (done8),
    .overrun      (ovr8)
  );

  digest_reader #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW), .OUT_WORDS(4)) dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .digest       (t_dg),
    .digest_valid (t_dv),
    .abort        (t_ab),
    .dout_if      (bus4.master),
    .busy         (busy4),
    .digest_done  (done4),
    .overrun      (ovr4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: per instance, the captured digest, the next word to return,
  // how many words are still owed, the one-cycle done pulse and the sticky overrun.
  logic [DW-1:0] m_cap  [2];
  int            m_pos  [2];
  int            m_left [2];
  bit            m_done [2];
  bit            m_ovr  [2];
  bit            m_dvp;

  logic [BW-1:0] k_word = 64'h1111_1111_1111_1111;
  logic [DW-1:0] dig_a, dig_b;

  typedef struct {
    bit dv;  bit rdy;
    int m8;  bit l8; bit d8; bit b8;
    int m4;  bit l4; bit d4; bit b4;
  } vec_t;
  vec_t vt[$];

  function automatic int nwords(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic logic [68:0] act_out(input int d);
    if (d == 0) return {bus8.dout, bus8.dout_valid, bus8.dout_last, busy8, done8, ovr8};
    return {bus4.dout, bus4.dout_valid, bus4.dout_last, busy4, done4, ovr4};
  endfunction

  function automatic logic [68:0] exp_out(input int d);
    logic [BW-1:0] w;
    bit s;
    s = (m_left[d] > 0);
    w = s ? BW'(m_cap[d] >> (BW * m_pos[d])) : '0;
    return {w, s, s && (m_left[d] == 1), s || m_done[d], m_done[d], m_ovr[d]};
  endfunction

  function automatic logic [68:0] exp_row(input vec_t v, input int d);
    int m;
    bit l, dn, b;
    logic [BW-1:0] w;
    m  = (d == 0) ? v.m8 : v.m4;
    l  = (d == 0) ? v.l8 : v.l4;
    dn = (d == 0) ? v.d8 : v.d4;
    b  = (d == 0) ? v.b8 : v.b4;
    w  = (m != 0) ? k_word * 64'(m) : '0;
    return {w, m != 0, l, b, dn, 1'b0};
  endfunction

  function automatic logic [DW-1:0] rand_dg();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cap[d]  = '0;
      m_pos[d]  = 0;
      m_left[d] = 0;
      m_done[d] = 1'b0;
      m_ovr[d]  = 1'b0;
    end
    m_dvp = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit rise;
    rise = t_dv && !m_dvp;
    for (int d = 0; d < 2; d++) begin
      if (t_ab) begin
        m_left[d] = 0;
        m_done[d] = 1'b0;
        m_ovr[d]  = 1'b0;
      end else if (m_done[d]) begin
        m_done[d] = 1'b0;
        if (rise) m_ovr[d] = 1'b1;
      end else if (m_left[d] > 0) begin
        if (rise) m_ovr[d] = 1'b1;
        if (t_rdy) begin
          m_pos[d]++;
          m_left[d]--;
          if (m_left[d] == 0) m_done[d] = 1'b1;
        end
      end else if (rise) begin
        m_cap[d]  = t_dg;
        m_pos[d]  = 0;
        m_left[d] = nwords(d);
      end
    end
    m_dvp = t_dv;
  endtask

  task automatic wait_check();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) check($sformatf("model dut%0d", d), act_out(d), exp_out(d));
  endtask

  task automatic drive(input bit dv, input logic [DW-1:0] dg, input bit ab, input bit rdy);
    t_dv  = dv;
    t_dg  = dg;
    t_ab  = ab;
    t_rdy = rdy;
    model_step();
  endtask

  task automatic cycle(input bit dv, input logic [DW-1:0] dg, input bit ab, input bit rdy);
    wait_check();
    drive(dv, dg, ab, rdy);
  endtask

  task automatic add(input bit dv, input bit rdy,
                     input int m8, input bit l8, input bit d8, input bit b8,
                     input int m4, input bit l4, input bit d4, input bit b4);
    vec_t v;
    v.dv = dv; v.rdy = rdy;
    v.m8 = m8; v.l8 = l8; v.d8 = d8; v.b8 = b8;
    v.m4 = m4; v.l4 = l4; v.d4 = d4; v.b4 = b4;
    vt.push_back(v);
  endtask

  initial begin
    int accepts;
    int dones;

    for (int i = 0; i < 8; i++) dig_a[64*i +: 64] = k_word * 64'(i + 1);
    dig_b = rand_dg();

    // Full-length read: rise sampled at the end of row 1 (cycle k).
    //   dv rdy  m8 l8 d8 b8  m4 l4 d4 b4
    add(0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1,  1, 0, 0, 1,  1, 0, 0, 1);
    add(1, 1,  2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 1,  3, 0, 0, 1,  3, 0, 0, 1);
    add(1, 1,  4, 0, 0, 1,  4, 1, 0, 1);
    add(1, 1,  5, 0, 0, 1,  0, 0, 1, 1);
    add(1, 1,  6, 0, 0, 1,  0, 0, 0, 0);
    add(1, 1,  7, 0, 0, 1,  0, 0, 0, 0);
    add(1, 1,  8, 1, 0, 1,  0, 0, 0, 0);
    add(1, 1,  0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    // Backpressure: dout_ready low on cycles k+2..k+4.
    add(0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1,  1, 0, 0, 1,  1, 0, 0, 1);
    add(1, 0,  2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 0,  2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 0,  2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 1,  2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 1,  3, 0, 0, 1,  3, 0, 0, 1);
    add(1, 1,  4, 0, 0, 1,  4, 1, 0, 1);
    add(1, 1,  5, 0, 0, 1,  0, 0, 1, 1);
    add(1, 1,  6, 0, 0, 1,  0, 0, 0, 0);
    add(1, 1,  7, 0, 0, 1,  0, 0, 0, 0);
    add(1, 1,  8, 1, 0, 1,  0, 0, 0, 0);
    add(1, 1,  0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    reset_n = 1'b0;
    t_dv = 1'b0; t_ab = 1'b0; t_rdy = 1'b1; t_dg = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset dut8", act_out(0), '0);
    check("reset dut4", act_out(1), '0);
    reset_n = 1'b1;
    drive(0, dig_a, 0, 1);

    foreach (vt[i]) begin
      wait_check();
      check($sformatf("vec %0d dut8", i), act_out(0), exp_row(vt[i], 0));
      check($sformatf("vec %0d dut4", i), act_out(1), exp_row(vt[i], 1));
      drive(vt[i].dv, dig_a, 0, vt[i].rdy);
    end

    // Overrun: second rise while dut8 returns word index 2..3.
    cycle(1, dig_a, 0, 1);
    cycle(1, dig_a, 0, 1);
    cycle(0, dig_a, 0, 1);
    cycle(1, dig_b, 0, 1);
    repeat (10) cycle(1, dig_b, 0, 1);
    wait_check();
    check("overrun sticky", {ovr8, ovr4}, 2'b11);
    drive(1, dig_b, 1, 1);
    wait_check();
    check("overrun cleared by abort", {ovr8, ovr4}, 2'b00);
    drive(1, dig_b, 0, 1);

    // Abort while word index 5 is on the bus.
    cycle(0, dig_a, 0, 1);
    cycle(1, dig_a, 0, 1);
    repeat (5) cycle(1, dig_a, 0, 1);
    wait_check();
    check("word 5 before abort", {bus8.dout, bus8.dout_valid}, {k_word * 64'd6, 1'b1});
    drive(1, dig_a, 1, 1);
    wait_check();
    check("after abort", {bus8.dout_valid, busy8, done8}, 3'b000);
    drive(0, dig_a, 0, 1);
    cycle(1, dig_b, 0, 1);
    wait_check();
    check("new digest word 0", {bus8.dout, bus8.dout_valid}, {dig_b[63:0], 1'b1});
    drive(1, dig_b, 0, 1);
    repeat (10) cycle(1, dig_b, 0, 1);

    // Abort in the same cycle as a rise: nothing captured.
    cycle(0, dig_a, 0, 1);
    cycle(1, dig_a, 1, 1);
    wait_check();
    check("abort with rise", {busy8, busy4}, 2'b00);
    drive(1, dig_a, 0, 1);
    repeat (3) cycle(1, dig_a, 0, 1);

    // Asynchronous reset mid-SEND with digest_valid still high at release.
    cycle(0, dig_a, 0, 1);
    cycle(1, dig_a, 0, 1);
    repeat (3) cycle(1, dig_a, 0, 1);
    wait_check();
    #1 reset_n = 1'b0;
    #1;
    check("async reset dut8", act_out(0), '0);
    check("async reset dut4", act_out(1), '0);
    model_reset();
    t_dg = dig_b;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) check($sformatf("in reset dut%0d", d), act_out(d), exp_out(d));
    reset_n = 1'b1;
    drive(1, dig_b, 0, 1);
    wait_check();
    check("capture at reset release", {bus8.dout, bus8.dout_valid}, {dig_b[63:0], 1'b1});
    drive(1, dig_b, 0, 1);
    repeat (10) cycle(1, dig_b, 0, 1);

    // Level hold: one capture, one 8-word return, no overrun.
    cycle(0, dig_a, 0, 1);
    accepts = 0;
    dones   = 0;
    for (int i = 0; i < 20; i++) begin
      wait_check();
      if (bus8.dout_valid && t_rdy) accepts++;
      if (done8) dones++;
      drive(1, dig_a, 0, 1);
    end
    check("level hold words", 32'(accepts), 32'd8);
    check("level hold done", 32'(dones), 32'd1);
    check("level hold no overrun", {ovr8, ovr4}, 2'b00);
    cycle(0, dig_a, 0, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit dv;
      dv = ($urandom_range(0, 5) == 0) ? !t_dv : t_dv;
      cycle(dv, rand_dg(), $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
    end
    wait_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digest_reader.md
# digest_reader

Output stage of the hash subsystem, downstream of the Blake2 hash engine that the controller drives. It captures the DIGEST_WIDTH-bit digest when the engine signals `digest_valid`. It then returns the digest to the processor as BUS_WIDTH-bit words over a valid/ready handshake, optionally truncated to OUT_WORDS words.

## Interface
- BUS_WIDTH, 64, processor word width.
- DIGEST_WIDTH, 512, engine digest width; must be a multiple of BUS_WIDTH.
- OUT_WORDS, DIGEST_WIDTH/BUS_WIDTH, number of words returned; 1 <= OUT_WORDS <= DIGEST_WIDTH/BUS_WIDTH.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- digest  in  DIGEST_WIDTH  digest from the hash engine.
- digest_valid  in  1  level from the engine; high while `digest` is valid.
- abort  in  1  synchronous clear, from the processor.
- dout  out  BUS_WIDTH  current digest word.
- dout_valid  out  1  `dout` is valid.
- dout_ready  in  1  processor accepts `dout` this cycle.
- dout_last  out  1  marks the final word (index OUT_WORDS-1).
- busy  out  1  a digest is being returned.
- digest_done  out  1  one-cycle pulse after the last word is accepted.
- overrun  out  1  sticky flag: a digest arrived while busy and was dropped.

## Operation
- **Edge detect:**
  - `dv_q` is `digest_valid` registered; it resets to 0.
  - A capture event is `digest_valid & ~dv_q`.
  - If `digest_valid` is already high when reset releases, that counts as a capture event.
- **States:** IDLE, SEND, DONE. Reset state is IDLE.
- **IDLE:**
  - On a capture event, load `digest` into the capture register, set idx=0 and go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `dout_valid` = 1.
  - `dout` = `digest_reg[BUS_WIDTH*idx +: BUS_WIDTH]`; word 0 is the least-significant BUS_WIDTH bits (Blake2 little-endian order).
  - `dout_last` = (idx == OUT_WORDS-1).
  - On `dout_valid & dout_ready`:
    - if `dout_last`, go to DONE;
    - otherwise idx = idx+1.
  - Without `dout_ready`, `dout`, `dout_last` and idx are held stable.
- **DONE:** `digest_done` = 1 for this single cycle, then go to IDLE.
- **busy** = (state != IDLE).
- **Overrun:**
  - A capture event in SEND or DONE sets `overrun`; that digest is dropped.
  - The word transfer in progress is unaffected.
  - `overrun` clears only on reset or `abort`.
- **abort:**
  - Next state is IDLE; idx=0.
  - `digest_reg`, `overrun`, `dout_valid`, `dout_last` and `digest_done` are cleared.
  - `dv_q` still updates, so a capture event in the same cycle as `abort` is consumed and not captured.
- **Outputs outside SEND:** `dout` = 0, `dout_valid` = 0, `dout_last` = 0.
- **Widths:** idx is max(1, $clog2(OUT_WORDS)) bits and never exceeds OUT_WORDS-1; there is no wrap-around.
- **Truncation:** digest bits above BUS_WIDTH*OUT_WORDS are captured but never output.

## Timing
- **Reset values:** all outputs 0, state IDLE, idx 0, `digest_reg` 0, `dv_q` 0.
- **Capture latency:** capture event sampled at edge k; `dout_valid` = 1 with word 0 from cycle k+1.
- **Throughput:** with `dout_ready` held high, words 0..OUT_WORDS-1 appear on cycles k+1..k+OUT_WORDS, one per cycle.
- **Completion:** `digest_done` is high on cycle k+OUT_WORDS+1; `busy` is high on cycles k+1..k+OUT_WORDS+1.
- **Next capture:** the earliest accepted next capture is sampled at the end of the DONE cycle's following IDLE cycle. A capture event in the DONE cycle is an overrun.
- **Handshake:** `dout_valid` never drops without acceptance, except on `abort` or reset. Each stall cycle adds one cycle to the total.
- **Asynchronous reset mid-SEND:** outputs go to 0 immediately and no `digest_done` is generated.

## Test plan
- **Full-length read:** reset; digest = 512'h…, with word i = 64'h1111_1111_1111_1111*(i+1); `digest_valid` rises at edge k; `dout_ready`=1.
  -> words 1x..8x on cycles k+1..k+8, `dout_last` only on cycle k+8, `digest_done` on k+9, `busy` low on k+10.
- **Backpressure:** same stimulus, `dout_ready` low on cycles k+2..k+4.
  -> word 1 held stable for 4 cycles, word order is intact, `digest_done` on k+12.
- **Truncation:** OUT_WORDS=4, same digest.
  -> only words 1x..4x are output, `dout_last` on the 4th word, `digest_done` the next cycle.
- **Overrun:** second `digest_valid` rise (toggle low then high) during SEND at word 3.
  -> `overrun`=1 and stays 1, remaining words still come from the first digest, the second digest is never output; `abort` then clears `overrun`.
- **Abort and reset:**
  - `abort` while `dout_valid`=1 at word 5 -> next cycle `dout_valid`=0, `busy`=0, no `digest_done`; a new rise then returns word 0 of the new digest.
  - `abort` in the same cycle as a rise -> no capture.
  - `reset_n` low mid-SEND -> all outputs 0 asynchronously.
- **Level hold:** `digest_valid` held high for 20 cycles.
  -> exactly one capture and one 8-word return, no `overrun`.
